// File: rtl/babbage_sweep_ctrl.sv
// babbage_sweep_ctrl: host-driven n-sweep sequencer for babbage_top.
// It issues one evaluation at a time and buffers each (n, result) pair in a
// first-word-fall-through FIFO that drains over a valid/ready stream.
// Optional watchdog abort: define BABBAGE_SWEEP_WDOG_EN.
module babbage_sweep_ctrl #(
  parameter int unsigned W           = 32,
  parameter int unsigned NW          = 7,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned WDOG_CYCLES = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sweep_go,
  input  logic [NW-1:0] n_first,
  input  logic [NW:0]   n_count,
  output logic          busy,
  output logic          sweep_done_tick,
  output logic          err,
  output logic          eng_start,
  output logic [NW-1:0] eng_n,
  input  logic          eng_ready,
  input  logic [W-1:0]  eng_result,
  input  logic          eng_done_tick,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [NW-1:0] res_n
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NCW = NW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t          state, state_nxt;
  logic [NCW-1:0]  cnt_q;
  logic [NCW-1:0]  issued;
  logic            accept;
  logic            push;
  logic            pop;
  logic            start_ok;
  logic            last_eval;
  logic            timeout;

  logic [W-1:0]    mem_d [FIFO_DEPTH];
  logic [NW-1:0]   mem_n [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   head_idx;
  logic            head_from_push;

  // Issue only when the engine is ready and a FIFO slot is guaranteed for the result
  assign start_ok  = eng_ready && (fifo_count < CW'(FIFO_DEPTH));
  assign last_eval = (issued == cnt_q);

`ifdef BABBAGE_SWEEP_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wdog_cnt;
  logic           err_q;

  // Cycle counter for the outstanding evaluation; the start cycle counts as one
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (eng_start) begin
      wdog_cnt <= WDW'(1);
    end else if (state == S_WAIT) begin
      wdog_cnt <= wdog_cnt + WDW'(1);
    end
  end

  // Abort timed so err/FINISH follow and the done tick lands WDOG_CYCLES after start
  assign timeout = (state == S_WAIT) && !eng_done_tick &&
                   (wdog_cnt == WDW'(WDOG_CYCLES - 2));

  // Sticky abort flag, cleared by the next accepted command
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_wdog;

  assign unused_wdog = ^32'(WDOG_CYCLES);
  assign timeout     = 1'b0;
  assign err         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (sweep_go) begin
          state_nxt = (n_count == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (start_ok) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done_tick) begin
          state_nxt = last_eval ? S_FINISH : S_ISSUE;
        end else if (timeout) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    accept    = 1'b0;
    eng_start = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE:  accept    = sweep_go;
      S_ISSUE: eng_start = start_ok;
      S_WAIT:  push      = eng_done_tick;
      default: ;
    endcase
  end

  // Sweep bookkeeping, engine n and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q           <= '0;
      issued          <= '0;
      eng_n           <= '0;
      busy            <= 1'b0;
      sweep_done_tick <= 1'b0;
    end else begin
      sweep_done_tick <= (state == S_FINISH);
      if (accept) begin
        cnt_q  <= n_count;
        issued <= '0;
        eng_n  <= n_first;
        busy   <= 1'b1;
      end
      if (state == S_FINISH) begin
        busy <= 1'b0;
      end
      if (eng_start) begin
        issued <= issued + NCW'(1);
      end
      // eng_n advances only after the result is captured, keeping it stable in WAIT
      if (push) begin
        eng_n <= eng_n + NW'(1);
      end
    end
  end

  assign pop            = res_valid && res_ready;
  assign count_nxt      = fifo_count + CW'(push) - CW'(pop);
  assign head_idx       = rd_ptr + AW'(pop);
  assign head_from_push = push && (fifo_count == CW'(pop));

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= eng_result;
      mem_n[wr_ptr] <= eng_n;
    end
  end

  // FIFO pointers and registered head-of-queue outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_n      <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= head_idx;
      fifo_count <= count_nxt;
      res_valid  <= (count_nxt != '0);
      if (head_from_push) begin
        res_data <= eng_result;
        res_n    <= eng_n;
      end else if (count_nxt != '0) begin
        res_data <= mem_d[head_idx];
        res_n    <= mem_n[head_idx];
      end
    end
  end

endmodule
